// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multiport register file.
package rf_pkg;

  typedef enum logic [0:0] {RF_INIT, RF_RUN} rf_state_e;

  localparam int unsigned RF_XLEN = 32;
  localparam int unsigned RF_NREG = 32;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 masking, masking while clearing, and the
// optional same-cycle write bypass (compiled in by RF_BYPASS_EN).
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned AW   = 5
) (
  input  logic            ready,
  input  logic [XLEN-1:0] stored,
  input  logic [AW-1:0]   raddr,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

`ifdef RF_BYPASS_EN
  // raddr != 0 is already required, so waddr != 0 follows from the match.
  logic hit;
  assign hit = we && (waddr == raddr);
`else
  logic hit;
  logic unused_bypass;
  assign hit           = 1'b0;
  assign unused_bypass = ^{we, waddr, wdata};
`endif

  always_comb begin
    rdata = stored;
    if (!ready || (raddr == '0)) begin
      rdata = '0;
    end else if (hit) begin
`ifdef RF_BYPASS_EN
      rdata = wdata;
`endif
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file with NRD combinational reads, one clocked write and a
// post-reset hardware clear. Optional write-to-read bypass via RF_BYPASS_EN.
module rf_multiport
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN = RF_XLEN,
  parameter  int unsigned NREG = RF_NREG,
  parameter  int unsigned NRD  = 2,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [NRD-1:0][AW-1:0]   raddr,
  output logic [NRD-1:0][XLEN-1:0] rdata,
  output logic                     ready
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q;

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;

  // Entry 0 is never written; its read is masked in every port.
  logic [XLEN-1:0] rf_q [NREG];

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = wdata;
    unique case (state_q)
      RF_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(NREG - 1)) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        mem_we = we && (waddr != '0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RF_INIT;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == RF_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      rf_q[mem_addr] <= mem_wdata;
    end
  end

  assign ready = ready_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_port (
      .ready (ready_q),
      .stored(rf_q[raddr[i]]),
      .raddr (raddr[i]),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[i])
    );
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed + randomized bench for rf_multiport against a behavioural model.
module tb_rf_multiport;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 3;
  localparam int unsigned AW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     we;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic                     ready;

  logic            we_s;
  logic [2:0]      waddr_s;
  logic [15:0]     wdata_s;
  logic [0:0][2:0] raddr_s;
  logic [0:0][15:0] rdata_s;
  logic            ready_s;

  rf_multiport #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata),
    .ready(ready)
  );

  rf_multiport #(.XLEN(16), .NREG(8), .NRD(1)) dut_s (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we_s),
    .waddr(waddr_s),
    .wdata(wdata_s),
    .raddr(raddr_s),
    .rdata(rdata_s),
    .ready(ready_s)
  );

  // Model: architectural contents after clear, plus edge count since reset.
  logic [XLEN-1:0] model [NREG];
  bit              ready_m;
  int              clr_cnt;
  int              checks = 0;
  int              fails  = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] expect_port(input int p);
    logic [AW-1:0] a;
    a = raddr[p];
    if (!ready_m || a == '0) return '0;
`ifdef RF_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s_p%0d", tag, p), rdata[p], expect_port(p));
    end
    check($sformatf("%s_ready", tag), {31'b0, ready}, {31'b0, ready_m});
  endtask

  task automatic reset_model();
    ready_m = 1'b0;
    clr_cnt = 0;
    for (int a = 0; a < NREG; a++) model[a] = '0;
  endtask

  // Advance one rising edge, committing the model's view of that edge.
  task automatic tick();
    if (rst_n) begin
      if (ready_m) begin
        if (we && waddr != '0) model[waddr] = wdata;
      end else begin
        clr_cnt++;
        if (clr_cnt == NREG - 1) ready_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    we      = 1'b1;
    waddr   = 5'd5;
    wdata   = 32'h1234;
    raddr[0] = 5'd0;
    raddr[1] = 5'd5;
    raddr[2] = 5'd5;
    we_s    = 1'b0;
    waddr_s = 3'd0;
    wdata_s = 16'h0;
    raddr_s[0] = 3'd7;
    reset_model();

    #12;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_ready_s", {31'b0, ready_s}, 32'd0);
    check_all("rst");
    rst_n = 1'b1;

    // Clear sequence with a write held on the whole time.
    for (int k = 1; k <= 31; k++) begin
      tick();
      check_all($sformatf("init%0d", k));
      check($sformatf("init%0d_ready_s", k), {31'b0, ready_s}, {31'b0, (k >= 7)});
    end
    we = 1'b0;
    #1;
    check("x5_ignored", rdata[1], 32'h0);

    // Small configuration: NREG=8, XLEN=16.
    we_s = 1'b1; waddr_s = 3'd7; wdata_s = 16'hBEEF;
    tick();
    we_s = 1'b0;
    #1;
    check("small_x7", {16'h0, rdata_s[0]}, 32'h0000BEEF);

    // Basic write/read on three ports.
    we = 1'b1; waddr = 5'd3; wdata = 32'hAAAAAAAA;
    tick();
    waddr = 5'd4; wdata = 32'h55555555;
    tick();
    we = 1'b0;
    raddr[0] = 5'd3; raddr[1] = 5'd4; raddr[2] = 5'd3;
    #1;
    check("basic_p0", rdata[0], 32'hAAAAAAAA);
    check("basic_p1", rdata[1], 32'h55555555);
    check("basic_p2", rdata[2], 32'hAAAAAAAA);
    check_all("basic");

    // x0 hardwire.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr[0] = 5'd0; raddr[1] = 5'd0; raddr[2] = 5'd0;
    #1;
    for (int p = 0; p < NRD; p++) check($sformatf("x0_now_p%0d", p), rdata[p], 32'h0);
    tick();
    we = 1'b0;
    #1;
    for (int p = 0; p < NRD; p++) check($sformatf("x0_next_p%0d", p), rdata[p], 32'h0);

    // Same-cycle read of the address being written.
    we = 1'b1; waddr = 5'd7; wdata = 32'h11;
    tick();
    wdata = 32'h22;
    raddr[0] = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle", rdata[0], 32'h22);
`else
    check("same_cycle", rdata[0], 32'h11);
`endif
    tick();
    we = 1'b0;
    #1;
    check("next_cycle", rdata[0], 32'h22);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = AW'($urandom);
      wdata = $urandom;
      for (int p = 0; p < NRD; p++) begin
        raddr[p] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
      end
      #1;
      check_all($sformatf("rand%0d", n));
      tick();
    end

    // Fill, then reset between edges.
    for (int a = 1; a < NREG; a++) begin
      we = 1'b1; waddr = AW'(a); wdata = $urandom | 32'h1;
      tick();
    end
    we = 1'b0;
    raddr[0] = 5'd31;
    #1;
    check("filled_x31", rdata[0], model[31]);
    rst_n = 1'b0;
    reset_model();
    #1;
    check("midrst_ready", {31'b0, ready}, 32'd0);
    check("midrst_ready_s", {31'b0, ready_s}, 32'd0);
    check("midrst_rdata", rdata[0], 32'h0);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("reclr%0d_ready", k), {31'b0, ready}, {31'b0, (k == 31)});
    end
    for (int a = 0; a < NREG; a++) begin
      for (int p = 0; p < NRD; p++) raddr[p] = AW'(a);
      #1;
      for (int p = 0; p < NRD; p++) check($sformatf("cleared_x%0d_p%0d", a, p), rdata[p], 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised successor to the single-issue RV32I register file. It provides `NRD` combinational read ports and one clocked write port. After reset, a hardware walker clears every entry to zero before the file accepts traffic, so register contents no longer depend on `initial` blocks. An optional write-to-read bypass is compiled in by macro. The block sits in the decode stage of the 5-stage pipeline; writeback drives its write port.

## Interface
- `XLEN`, 32, data width in bits
- `NREG`, 32, number of architectural registers; power of two, ≥ 4
- `NRD`, 2, number of read ports, 1..4
- `AW` (localparam), `$clog2(NREG)`, address width

- `clk` input 1: single clock; all state updates on the rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `we` input 1: write enable
- `waddr` input AW: write address
- `wdata` input XLEN: write data
- `raddr` input [NRD][AW]: read addresses, one per port
- `rdata` output [NRD][XLEN]: read data, one per port
- `ready` output 1: high once the clear sequence has finished

## Operation
- State machine: `RF_INIT`, `RF_RUN`.
- Reset:
  - `rst_n` low forces state `RF_INIT`, clear counter `clr_idx` = 1, `ready` = 0. This takes effect immediately, independent of `clk`.
  - The storage array has no reset.
- `RF_INIT`:
  - Each rising edge writes 0 to `rf[clr_idx]`, then increments `clr_idx`.
  - On the edge that clears entry NREG-1, the state moves to `RF_RUN` and `ready` goes to 1.
  - External `we` is ignored throughout `RF_INIT`.
  - All `rdata` ports return 0.
- `RF_RUN`:
  - If `we` is high and `waddr` ≠ 0, `rf[waddr]` ← `wdata` on the rising edge.
  - A write to address 0 is discarded.
- Register x0:
  - Never stored.
  - Any port with `raddr` = 0 returns 0 in every state.
- Read ports:
  - Combinational, independent, and identical in behaviour.
  - Several ports may read the same address in one cycle.
- Reset mid-operation:
  - Asserting `rst_n` during `RF_INIT` or `RF_RUN` restarts the clear from entry 1.
  - A write sampled on the same edge that `rst_n` falls is lost.
- Width rules:
  - Full-width writes only; no byte enables.
  - Addresses are AW bits, so every address is in range.

## Timing
- Write latency:
  - Without bypass, a write committed at edge N is visible on `rdata` from cycle N+1.
  - With bypass, the written value is visible in the same cycle (see Configuration).
- Read latency: 0 cycles, pure combinational path from `raddr` to `rdata`.
- Clear duration: NREG-1 rising edges after `rst_n` deasserts. For NREG=32, `ready` rises after the 31st edge.
- `ready` is registered and is glitch-free.
- Once set, `ready` stays 1 until the next reset.

## Configuration
- `RF_BYPASS_EN` defined:
  - Condition: `ready`=1, `we`=1, `waddr` ≠ 0, and `raddr[i]` == `waddr`.
  - Effect: port i returns `wdata` combinationally in the current cycle.
  - This removes the pipeline's WB→ID hazard.
  - All read ports are bypassed independently.
- `RF_BYPASS_EN` undefined:
  - Reads return stored contents only.
  - A same-cycle read of the address being written returns the old value.

## Structure
- Shared package `rf_pkg` holds:
  - enum `rf_state_e {RF_INIT, RF_RUN}`
  - the default `XLEN`/`NREG` constants used by the core.
- One sub-module, `rf_read_port`:
  - One read port: x0 masking, INIT masking and the bypass mux.
  - Instantiated NRD times in a generate loop.
- The clear FSM, counter and storage array live in the top-level `rf_multiport`.

## Test plan
- Reset then hold: release `rst_n` and drive `we`=1, `waddr`=5, `wdata`=0x1234 throughout INIT.
  - `ready`=0 for 31 edges, then 1.
  - x5 reads 0: the write was ignored.
- Basic write/read, NRD=3: after `ready`, write x3=0xAAAAAAAA and x4=0x55555555.
  - Next cycle, ports 0/1/2 reading x3/x4/x3 return 0xAAAAAAAA / 0x55555555 / 0xAAAAAAAA.
- x0 hardwire: write x0=0xFFFFFFFF.
  - All ports reading address 0 return 0 both in that cycle and the following one.
- Same-cycle read of write address: x7 holds 0x11; write x7=0x22 while port 0 reads x7.
  - With `RF_BYPASS_EN`: returns 0x22 that cycle.
  - Without `RF_BYPASS_EN`: returns 0x11 that cycle, then 0x22 next cycle.
- Reset mid-run: after filling x1..x31 with nonzero values, pulse `rst_n` low between clock edges.
  - `ready` drops immediately.
  - After 31 edges, every register reads 0.
- Parameter sweep: NREG=8, XLEN=16.
  - `ready` after 7 edges.
  - Write x7=0xBEEF, read back 0xBEEF.
